// File: rtl/chip8_sprite_blitter.sv
// Multi-cycle CHIP-8 sprite draw / screen clear engine with clip or wrap edge handling.
// Define CHIP8_BLIT_SPRITE16_EN to make a DRAW with n=0 draw a 16x16 sprite.
module chip8_sprite_blitter #(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 32,
  parameter int ADDR_W   = 12,
  parameter int FB_AW    = $clog2(SCREEN_W*SCREEN_H)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [7:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [3:0]        cmd_n,
  input  logic [ADDR_W-1:0] cmd_index,
  input  logic              clip_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              fb_rd_en,
  output logic              fb_wr_en,
  output logic [FB_AW-1:0]  fb_addr,
  input  logic              fb_rd_data,
  output logic              fb_wr_data,
  output logic              busy,
  output logic              done,
  output logic              collision
);
  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam logic [XW+4:0]    W_LIM    = (XW+5)'(SCREEN_W);
  localparam logic [YW+5:0]    H_LIM    = (YW+6)'(SCREEN_H);
  localparam logic [FB_AW-1:0] CLR_LAST = FB_AW'(SCREEN_W*SCREEN_H-1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_COL, S_PIX_RD, S_PIX_WR, S_CLEAR, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x0_q, x0_d;
  logic [YW-1:0]     y0_q, y0_d;
  logic [4:0]        nrows_q, nrows_d;
  logic [4:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [15:0]       bits_q, bits_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              clip_q, clip_d;
  logic              wide_q, wide_d;
  logic              hi_q, hi_d;
  logic [FB_AW-1:0]  clr_q, clr_d;
  logic              coll_q, coll_d;

  logic [XW+4:0]     xsum;
  logic [YW+5:0]     ysum;
  logic              col_clip, row_clip_next, pix_on, advance;
  logic [3:0]        last_col;
  logic [FB_AW-1:0]  pix_addr;
  logic [ADDR_W-1:0] rd_addr;

  always_comb begin
    xsum          = (XW+5)'(x0_q) + (XW+5)'(col_q);
    ysum          = (YW+6)'(y0_q) + (YW+6)'(row_q);
    col_clip      = clip_q && (xsum >= W_LIM);
    row_clip_next = clip_q && ((ysum + (YW+6)'(1)) >= H_LIM);
    // Row bytes sit left-justified in bits_q, so column c maps to bit 15-c.
    pix_on        = bits_q[~col_q] && !col_clip;
    last_col      = wide_q ? 4'd15 : 4'd7;
    pix_addr      = FB_AW'({ysum[YW-1:0], xsum[XW-1:0]});
    rd_addr       = idx_q + ADDR_W'(wide_q ? {row_q, hi_q} : {1'b0, row_q});
  end

  always_comb begin
    state_d = state_q; x0_d = x0_q; y0_d = y0_q; nrows_d = nrows_q;
    row_d = row_q; col_d = col_q; bits_d = bits_q; idx_d = idx_q;
    clip_d = clip_q; wide_d = wide_q; hi_d = hi_q; clr_d = clr_q; coll_d = coll_q;
    cmd_ready = 1'b0; busy = 1'b0; done = 1'b0;
    mem_rd_en = 1'b0; mem_rd_addr = '0;
    fb_rd_en = 1'b0; fb_wr_en = 1'b0; fb_addr = '0; fb_wr_data = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: cmd_ready = 1'b1;
      S_FETCH: begin
        busy = 1'b1; mem_rd_en = 1'b1; mem_rd_addr = rd_addr;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        busy = 1'b1;
        if (wide_q && !hi_q) begin
          bits_d[15:8] = mem_rd_data; hi_d = 1'b1; state_d = S_FETCH;
        end else begin
          if (wide_q) bits_d[7:0] = mem_rd_data;
          else        bits_d = {mem_rd_data, 8'h00};
          hi_d = 1'b0; col_d = '0; state_d = S_COL;
        end
      end
      S_COL: begin
        busy = 1'b1;
        if (pix_on) state_d = S_PIX_RD;
        else        advance = 1'b1;
      end
      S_PIX_RD: begin
        busy = 1'b1; fb_rd_en = 1'b1; fb_addr = pix_addr;
        state_d = S_PIX_WR;
      end
      S_PIX_WR: begin
        busy = 1'b1; fb_wr_en = 1'b1; fb_addr = pix_addr;
        fb_wr_data = ~fb_rd_data;
        if (fb_rd_data) coll_d = 1'b1;
        advance = 1'b1;
      end
      S_CLEAR: begin
        busy = 1'b1; fb_wr_en = 1'b1; fb_addr = clr_q;
        if (clr_q == CLR_LAST) state_d = S_DONE;
        else                   clr_d = clr_q + 1'b1;
      end
      S_DONE: begin
        done = 1'b1; cmd_ready = 1'b1; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Rows below the screen in clip mode can only follow the current one, so stop here.
    if (advance) begin
      if (col_q != last_col) begin
        col_d = col_q + 1'b1; state_d = S_COL;
      end else if (row_q == 5'(nrows_q - 5'd1) || row_clip_next) begin
        state_d = S_DONE;
      end else begin
        row_d = row_q + 1'b1; state_d = S_FETCH;
      end
    end

    if (cmd_valid && cmd_ready) begin
      x0_d = XW'(int'(cmd_x) % SCREEN_W);
      y0_d = YW'(int'(cmd_y) % SCREEN_H);
      idx_d = cmd_index; clip_d = clip_en;
      row_d = '0; col_d = '0; hi_d = 1'b0; clr_d = '0; wide_d = 1'b0;
      if (cmd_op) begin
        state_d = S_CLEAR;
      end else begin
        coll_d = 1'b0;
        if (cmd_n != 4'd0) begin
          nrows_d = {1'b0, cmd_n}; state_d = S_FETCH;
        end else begin
`ifdef CHIP8_BLIT_SPRITE16_EN
          nrows_d = 5'd16; wide_d = 1'b1; state_d = S_FETCH;
`else
          nrows_d = 5'd0; state_d = S_DONE;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE; x0_q <= '0; y0_q <= '0; nrows_q <= '0;
      row_q <= '0; col_q <= '0; bits_q <= '0; idx_q <= '0;
      clip_q <= 1'b0; wide_q <= 1'b0; hi_q <= 1'b0; clr_q <= '0; coll_q <= 1'b0;
    end else begin
      state_q <= state_d; x0_q <= x0_d; y0_q <= y0_d; nrows_q <= nrows_d;
      row_q <= row_d; col_q <= col_d; bits_q <= bits_d; idx_q <= idx_d;
      clip_q <= clip_d; wide_q <= wide_d; hi_q <= hi_d; clr_q <= clr_d; coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Scoreboard bench for chip8_sprite_blitter: 64x32 main instance plus a 128x64 instance for CLEAR.
module tb_chip8_sprite_blitter;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_op = 1'b0, clip_en = 1'b0;
  logic [7:0]    cmd_x = '0, cmd_y = '0;
  logic [3:0]    cmd_n = '0;
  logic [AW-1:0] cmd_index = '0;
  logic          cmd_ready, busy, done, collision;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [7:0]    mem_rd_data = '0;
  logic          fb_rd_en, fb_wr_en, fb_wr_data;
  logic          fb_rd_data = 1'b0;
  logic [10:0]   fb_addr;

  logic          cmd_valid2 = 1'b0;
  logic          cmd_ready2, busy2, done2, collision2, mem_rd_en2;
  logic [AW-1:0] mem_rd_addr2;
  logic [7:0]    mem_rd_data2 = '0;
  logic          fb_rd_en2, fb_wr_en2, fb_wr_data2;
  logic          fb_rd_data2 = 1'b0;
  logic [12:0]   fb_addr2;

  chip8_sprite_blitter #(.SCREEN_W(64), .SCREEN_H(32), .ADDR_W(AW)) dut (
    .clk_in(clk), .rst_in(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_index(cmd_index),
    .clip_en(clip_en), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .fb_rd_en(fb_rd_en), .fb_wr_en(fb_wr_en), .fb_addr(fb_addr),
    .fb_rd_data(fb_rd_data), .fb_wr_data(fb_wr_data), .busy(busy), .done(done),
    .collision(collision));

  chip8_sprite_blitter #(.SCREEN_W(128), .SCREEN_H(64), .ADDR_W(AW)) dut_big (
    .clk_in(clk), .rst_in(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n), .cmd_index(cmd_index),
    .clip_en(clip_en), .mem_rd_en(mem_rd_en2), .mem_rd_addr(mem_rd_addr2),
    .mem_rd_data(mem_rd_data2), .fb_rd_en(fb_rd_en2), .fb_wr_en(fb_wr_en2), .fb_addr(fb_addr2),
    .fb_rd_data(fb_rd_data2), .fb_wr_data(fb_wr_data2), .busy(busy2), .done(done2),
    .collision(collision2));

  logic [7:0] mem [0:4095];
  bit         fb  [0:2047];

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    if (fb_rd_en)  fb_rd_data  <= fb[fb_addr];
    if (fb_wr_en)  fb[fb_addr] <= fb_wr_data;
  end

  typedef struct { int addr; bit data; } wr_t;
  wr_t exp_wr[$];
  int  exp_rd[$];
  wr_t e;
  int  er;
  int  checks = 0, errors = 0;
  int  rd_cnt = 0, big_exp = 0;

  function automatic void push_wr(input int a, input bit d);
    wr_t w;
    w.addr = a; w.data = d;
    exp_wr.push_back(w);
  endfunction

  // Monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (fb_wr_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL fb_wr_unexpected: got addr=%0d data=%0b, expected no write", fb_addr, fb_wr_data);
      end else begin
        e = exp_wr.pop_front();
        if (int'(fb_addr) !== e.addr || fb_wr_data !== e.data) begin
          errors++;
          $display("FAIL fb_wr: got addr=%0d data=%0b, expected addr=%0d data=%0b",
                   fb_addr, fb_wr_data, e.addr, e.data);
        end
      end
    end
    if (mem_rd_en) begin
      rd_cnt++;
      if (exp_rd.size() > 0) begin
        er = exp_rd.pop_front();
        checks++;
        if (int'(mem_rd_addr) !== er) begin
          errors++;
          $display("FAIL mem_rd_addr: got %0h expected %0h", mem_rd_addr, er);
        end
      end
    end
    if (fb_wr_en2) begin
      checks++;
      if (int'(fb_addr2) !== big_exp || fb_wr_data2 !== 1'b0) begin
        errors++;
        $display("FAIL big_clear_wr: got addr=%0d data=%0b expected addr=%0d data=0",
                 fb_addr2, fb_wr_data2, big_exp);
      end
      big_exp++;
    end
  end

  task automatic drive_cmd(input logic op, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] n, input logic [AW-1:0] idx, input logic clip);
    @(negedge clk);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_n = n; cmd_index = idx; clip_en = clip;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Counts rising edges after the acceptance edge until done is seen; bounded.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, busy, done, collision} !== 4'b1000) begin
      errors++; $display("FAIL reset_status: got rdy/busy/done/coll=%b expected 1000", {cmd_ready, busy, done, collision});
    end
    checks++;
    if ({mem_rd_en, fb_rd_en, fb_wr_en} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {mem_rd_en, fb_rd_en, fb_wr_en});
    end
    checks++;
    if (mem_rd_addr !== '0 || fb_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got mem=%0h fb=%0h expected 0/0", mem_rd_addr, fb_addr);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_draw_basic();
    int cyc;
    for (int i = 0; i < 4; i++) push_wr(i, 1'b1);
    drive_cmd(1'b0, 8'd0, 8'd0, 4'd1, 12'h100, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 18) begin errors++; $display("FAIL draw_latency: got %0d expected 18", cyc); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL draw_coll0: got %b expected 0", collision); end
    for (int i = 0; i < 4; i++) push_wr(i, 1'b0);
    drive_cmd(1'b0, 8'd0, 8'd0, 4'd1, 12'h100, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 18) begin errors++; $display("FAIL redraw_latency: got %0d expected 18", cyc); end
    checks++;
    if (collision !== 1'b1) begin errors++; $display("FAIL redraw_coll: got %b expected 1", collision); end
  endtask

  task automatic test_edge_modes();
    int cyc;
    push_wr(382, 1'b1); push_wr(383, 1'b1);
    for (int i = 320; i < 326; i++) push_wr(i, 1'b1);
    drive_cmd(1'b0, 8'd62, 8'd5, 4'd1, 12'h110, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 26) begin errors++; $display("FAIL wrap_latency: got %0d expected 26", cyc); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("FAIL wrap_coll: got %b expected 0", collision); end
    push_wr(382, 1'b0); push_wr(383, 1'b0);
    drive_cmd(1'b0, 8'd62, 8'd5, 4'd1, 12'h110, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 14) begin errors++; $display("FAIL clip_latency: got %0d expected 14", cyc); end
    checks++;
    if (collision !== 1'b1) begin errors++; $display("FAIL clip_coll: got %b expected 1", collision); end
  endtask

  task automatic test_vertical();
    int cyc, rd0;
    push_wr(1984, 1'b1); push_wr(0, 1'b1);
    drive_cmd(1'b0, 8'd0, 8'd31, 4'd2, 12'h120, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 24) begin errors++; $display("FAIL vwrap_latency: got %0d expected 24", cyc); end
    push_wr(1984, 1'b0);
    rd0 = rd_cnt;
    drive_cmd(1'b0, 8'd0, 8'd31, 4'd2, 12'h120, 1'b1);
    wait_done(cyc);
    checks++;
    if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL vclip_reads: got %0d expected 1", rd_cnt - rd0); end
    checks++;
    if (cyc !== 12) begin errors++; $display("FAIL vclip_latency: got %0d expected 12", cyc); end
    checks++;
    if (collision !== 1'b1) begin errors++; $display("FAIL vclip_coll: got %b expected 1", collision); end
  endtask

  task automatic test_n_zero();
    int cyc, rd0;
    rd0 = rd_cnt;
    drive_cmd(1'b0, 8'd0, 8'd0, 4'd0, 12'h100, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 0) begin errors++; $display("FAIL nzero_latency: got %0d expected 0", cyc); end
    checks++;
    if (collision !== 1'b0 || rd_cnt != rd0) begin
      errors++; $display("FAIL nzero_state: got coll=%b reads=%0d expected coll=0 reads=0", collision, rd_cnt - rd0);
    end
  endtask

  task automatic test_modulo_index();
    int cyc;
    push_wr(518, 1'b1);
    drive_cmd(1'b0, 8'd70, 8'd40, 4'd1, 12'h120, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 12) begin errors++; $display("FAIL modulo_latency: got %0d expected 12", cyc); end
    exp_rd.push_back(12'hFFF); exp_rd.push_back(12'h000);
    drive_cmd(1'b0, 8'd0, 8'd0, 4'd2, 12'hFFF, 1'b0);
    wait_done(cyc);
    checks++;
    if (cyc !== 20 || exp_rd.size() != 0) begin
      errors++; $display("FAIL index_wrap: got cyc=%0d pending_reads=%0d expected 20/0", cyc, exp_rd.size());
    end
  endtask

  task automatic test_clear();
    int cyc;
    bit rdy_hi;
    for (int i = 0; i < 2048; i++) push_wr(i, 1'b0);
    drive_cmd(1'b1, 8'd0, 8'd0, 4'd0, 12'h000, 1'b0);
    cyc = 0; rdy_hi = 1'b0;
    while (done !== 1'b1 && cyc < 20000) begin
      if (cmd_ready) rdy_hi = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 2048) begin errors++; $display("FAIL clear_latency: got %0d expected 2048", cyc); end
    checks++;
    if (rdy_hi !== 1'b0) begin errors++; $display("FAIL clear_ready: got ready high while busy, expected low"); end
    checks++;
    if (exp_wr.size() != 0) begin errors++; $display("FAIL clear_writes: got %0d missing, expected 0", exp_wr.size()); end
  endtask

  task automatic test_clear_big();
    int cyc;
    @(negedge clk);
    cmd_op = 1'b1; cmd_valid2 = 1'b1;
    @(posedge clk); #1;
    cmd_valid2 = 1'b0;
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (cyc !== 8192 || big_exp !== 8192) begin
      errors++; $display("FAIL big_clear: got cyc=%0d writes=%0d expected 8192/8192", cyc, big_exp);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, wn;
    push_wr(650, 1'b1);
    drive_cmd(1'b0, 8'd10, 8'd10, 4'd1, 12'h130, 1'b0);
    wait_done(cyc);
    push_wr(650, 1'b0); push_wr(651, 1'b1);
    drive_cmd(1'b0, 8'd10, 8'd10, 4'd4, 12'h140, 1'b0);
    wn = 0; cyc = 0;
    while (cyc < 200) begin
      if (fb_wr_en) begin
        wn++;
        if (wn == 3) break;
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (wn !== 3 || collision !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got writes=%0d coll=%b expected 3/1", wn, collision);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd_en, fb_rd_en, fb_wr_en} !== 3'b000) begin
      errors++; $display("FAIL abort_strobes: got %b expected 000", {mem_rd_en, fb_rd_en, fb_wr_en});
    end
    checks++;
    if ({busy, cmd_ready, collision} !== 3'b010) begin
      errors++; $display("FAIL abort_status: got busy/rdy/coll=%b expected 010", {busy, cmd_ready, collision});
    end
    @(negedge clk);
    rst = 1'b0;
    cmd_op = 1'b0; cmd_x = 8'd20; cmd_y = 8'd20; cmd_n = 4'd1; cmd_index = 12'h130; clip_en = 1'b0;
    cmd_valid = 1'b1;
    push_wr(1300, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL post_reset_accept: got busy=%b expected 1", busy); end
    wait_done(cyc);
    checks++;
    if (cyc !== 12) begin errors++; $display("FAIL post_reset_latency: got %0d expected 12", cyc); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'hF0;
    mem[12'h110] = 8'hFF;
    mem[12'h120] = 8'h80; mem[12'h121] = 8'h80;
    mem[12'h130] = 8'h80;
    mem[12'h140] = 8'hC0; mem[12'h141] = 8'h80; mem[12'h142] = 8'h80; mem[12'h143] = 8'h80;
    test_reset();
    test_draw_basic();
    test_edge_modes();
    test_vertical();
    test_n_zero();
    test_modulo_index();
    test_clear();
    test_clear_big();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got wr=%0d rd=%0d pending, expected 0/0", exp_wr.size(), exp_rd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
